// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-lane writes, fixed-latency reads and out-of-window error flagging.
// Define SRAM_RESP_PERF_CNT_EN to add the rd_cnt/wr_cnt access counters.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  select,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        err_sticky
`ifdef SRAM_RESP_PERF_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned Last  = READ_LATENCY - 1;

  logic [31:0]           mem_q [Depth];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_win;
  logic                  rd_req;
  logic                  wr_req;
  logic                  unused_addr_lsb;

  assign word_idx        = addr[ADDR_WIDTH+1:2];
  assign in_win          = (addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign wr_req          = memwrite;
  // A simultaneous read+write request is a write only.
  assign rd_req          = memread & ~memwrite;
  assign unused_addr_lsb = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (wr_req && in_win) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (select[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  logic        pipe_vld_q  [READ_LATENCY];
  logic [31:0] pipe_data_q [READ_LATENCY];
  logic        pipe_err_q  [READ_LATENCY];
  logic        wr_err_q;
  logic        err_sticky_q;

  // Stage 0 samples the array at the request edge, so a same-edge write is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < READ_LATENCY; k++) begin
        pipe_vld_q[k]  <= 1'b0;
        pipe_data_q[k] <= '0;
        pipe_err_q[k]  <= 1'b0;
      end
      wr_err_q     <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      pipe_vld_q[0] <= rd_req;
      pipe_err_q[0] <= rd_req & ~in_win;
      if (rd_req) begin
        pipe_data_q[0] <= in_win ? mem_q[word_idx] : '0;
      end
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_err_q[k] <= pipe_err_q[k-1];
        if (pipe_vld_q[k-1]) begin
          pipe_data_q[k] <= pipe_data_q[k-1];
        end
      end
      wr_err_q     <= wr_req & ~in_win;
      err_sticky_q <= err_sticky_q | err;
    end
  end

  // Data stages only load on a valid entry, so rdata holds between completions.
  assign rdata       = pipe_data_q[Last];
  assign rdata_valid = pipe_vld_q[Last];
  assign err         = (pipe_vld_q[Last] & pipe_err_q[Last]) | wr_err_q;
  assign err_sticky  = err_sticky_q | err;

`ifdef SRAM_RESP_PERF_CNT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_q + 32'(rd_req);
      wr_cnt_q <= wr_cnt_q + 32'(wr_req);
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: three responders (READ_LATENCY 1..3) share one directed stimulus stream.
module tb_data_sram_responder;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        memread  = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr     = '0;
  logic [31:0] wdata    = '0;
  logic [3:0]  select   = '0;

  logic [31:0] rdata  [3];
  logic        vld    [3];
  logic        err    [3];
  logic        sticky [3];
`ifdef SRAM_RESP_PERF_CNT_EN
  logic [31:0] rdc [3];
  logic [31:0] wrc [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_responder #(
      .ADDR_WIDTH  (10),
      .BASE_ADDR   (32'h0000_0000),
      .READ_LATENCY(g + 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .memread    (memread),
      .memwrite   (memwrite),
      .addr       (addr),
      .wdata      (wdata),
      .select     (select),
      .rdata      (rdata[g]),
      .rdata_valid(vld[g]),
      .err        (err[g]),
      .err_sticky (sticky[g])
`ifdef SRAM_RESP_PERF_CNT_EN
      ,
      .rd_cnt     (rdc[g]),
      .wr_cnt     (wrc[g])
`endif
    );
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          issue;
  } exp_t;

  exp_t exp_q [$];
  int   werr_q [$];
  int   hd [3] = '{0, 0, 0};
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   rd_n   = 0;
  int   wr_n   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d (lat %0d) cycle %0d: got %h, required %h",
               name, i, i + 1, cyc, act, exp);
    end
  endtask

  function automatic bit werr_now();
    foreach (werr_q[j]) if (werr_q[j] == cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mon(input int i);
    bit we;
    we = werr_now();
    if (vld[i]) begin
      if (hd[i] >= exp_q.size()) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid dut%0d cycle %0d: got rdata_valid=1, required 0", i, cyc);
      end else begin
        chk("rd_cycle", i, cyc, exp_q[hd[i]].issue + i + 1);
        chk("rdata", i, rdata[i], exp_q[hd[i]].data);
        chk("rd_err", i, {31'b0, err[i]}, {31'b0, exp_q[hd[i]].err | we});
        hd[i]++;
      end
    end else begin
      if (hd[i] < exp_q.size() && exp_q[hd[i]].issue + i + 1 < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_valid dut%0d cycle %0d: got no completion, required one at %0d",
                 i, cyc, exp_q[hd[i]].issue + i + 1);
        hd[i]++;
      end
      if (err[i] || we) chk("wr_err", i, {31'b0, err[i]}, {31'b0, we});
    end
  endtask

  always @(negedge clk) begin
    if (rst) for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic op_idle();
    @(posedge clk);
    #1;
    memread  = 1'b0;
    memwrite = 1'b0;
    select   = 4'h0;
  endtask

  task automatic op_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit oow, input bit also_rd);
    @(posedge clk);
    #1;
    memwrite = 1'b1;
    memread  = also_rd;
    addr     = a;
    wdata    = d;
    select   = s;
    wr_n++;
    if (oow) werr_q.push_back(cyc + 1);
  endtask

  // select is deliberately zero on reads: it must not mask read data.
  task automatic op_read(input logic [31:0] a, input logic [31:0] expd, input bit experr);
    @(posedge clk);
    #1;
    memread  = 1'b1;
    memwrite = 1'b0;
    addr     = a;
    select   = 4'h0;
    exp_q.push_back('{data: expd, err: experr, issue: cyc});
    rd_n++;
  endtask

  task automatic chk_idle_state(input string tag, input logic [31:0] exp_rdata,
                                input logic exp_sticky);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_rdata"}, i, rdata[i], exp_rdata);
      chk({tag, "_valid"}, i, {31'b0, vld[i]}, 32'd0);
      chk({tag, "_err"}, i, {31'b0, err[i]}, 32'd0);
      chk({tag, "_sticky"}, i, {31'b0, sticky[i]}, {31'b0, exp_sticky});
    end
  endtask

  task automatic chk_counters(input string tag, input int rd_exp, input int wr_exp);
`ifdef SRAM_RESP_PERF_CNT_EN
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_rd_cnt"}, i, rdc[i], rd_exp);
      chk({tag, "_wr_cnt"}, i, wrc[i], wr_exp);
    end
`else
    if (rd_exp < 0 || wr_exp < 0) $display("negative counter expectation in %s", tag);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle_state("reset", 32'h0, 1'b0);
    chk_counters("reset", 0, 0);
    rst = 1'b1;

    op_write(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    op_read(32'h10, 32'hDEAD_BEEF, 1'b0);

    op_write(32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
    op_write(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0);
    op_read(32'h20, 32'h11BB_33DD, 1'b0);

    op_write(32'h0, 32'd1, 4'hF, 1'b0, 1'b0);
    op_write(32'h4, 32'd2, 4'hF, 1'b0, 1'b0);
    op_write(32'h8, 32'd3, 4'hF, 1'b0, 1'b0);
    op_read(32'h0, 32'd1, 1'b0);
    op_read(32'h4, 32'd2, 1'b0);
    op_read(32'h8, 32'd3, 1'b0);

    // Read-then-write returns the old word; write-then-read returns the new one.
    op_write(32'h30, 32'd5, 4'hF, 1'b0, 1'b0);
    op_read(32'h30, 32'd5, 1'b0);
    op_write(32'h30, 32'd9, 4'hF, 1'b0, 1'b0);
    op_read(32'h30, 32'd9, 1'b0);
    op_write(32'h34, 32'd7, 4'hF, 1'b0, 1'b0);
    op_read(32'h34, 32'd7, 1'b0);

    op_write(32'h10, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0);
    op_read(32'h10, 32'hDEAD_BEEF, 1'b0);
    repeat (4) op_idle();
    chk_idle_state("hold", 32'hDEAD_BEEF, 1'b0);

    op_read(32'h0001_0000, 32'h0, 1'b1);
    op_write(32'h0001_0010, 32'h0, 4'hF, 1'b1, 1'b0);
    op_read(32'h10, 32'hDEAD_BEEF, 1'b0);

    op_write(32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
    op_read(32'h40, 32'hCAFE_F00D, 1'b0);
    repeat (4) op_idle();
    chk_idle_state("post_err", 32'hCAFE_F00D, 1'b1);
    chk_counters("run", rd_n, wr_n);

    op_read(32'h10, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk);
    #1;
    memread = 1'b0;
    rst     = 1'b0;
    for (int i = 0; i < 3; i++) hd[i] = exp_q.size();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) op_idle();
    chk_idle_state("midreset", 32'h0, 1'b0);
    chk_counters("midreset", 0, 0);

    op_read(32'h8, 32'd3, 1'b0);
    repeat (5) op_idle();
    for (int i = 0; i < 3; i++) chk("drained", i, hd[i], exp_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
